// File: rtl/dist_ram_ctrl_pkg.sv
// Shared types for the Dist_RAM_sync port controller: access size, FSM states and lane geometry.
package dist_ram_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LDAT,
        ST_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dist_ram_lane_fmt.sv
// Byte-lane formatting: extracts and extends load data, and merges sub-word store data into
// the word read back from the RAM (the RAM has no byte enables).
module dist_ram_lane_fmt
    import dist_ram_ctrl_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  size_t             size,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] ld_data,
    output logic [WORD_W-1:0] st_data
);

    logic [LANE_W-1:0]   byte_sel;
    logic [2*LANE_W-1:0] half_sel;
    logic                fill_b;
    logic                fill_h;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: LANE_W];
        half_sel = addr_lo[1] ? word[WORD_W-1:2*LANE_W] : word[2*LANE_W-1:0];
        fill_b   = ~is_unsigned & byte_sel[LANE_W-1];
        fill_h   = ~is_unsigned & half_sel[2*LANE_W-1];
        ld_data  = '0;
        st_data  = word;
        case (size)
            SZ_B: begin
                ld_data = {{(WORD_W-LANE_W){fill_b}}, byte_sel};
                st_data[{addr_lo, 3'b000} +: LANE_W] = wdata[LANE_W-1:0];
            end
            SZ_H: begin
                ld_data = {{(WORD_W-2*LANE_W){fill_h}}, half_sel};
                if (addr_lo[1])
                    st_data[WORD_W-1:2*LANE_W] = wdata[2*LANE_W-1:0];
                else
                    st_data[2*LANE_W-1:0] = wdata[2*LANE_W-1:0];
            end
            SZ_W: begin
                ld_data = word;
                st_data = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dist_ram_port_ctrl.sv
// Load/store controller for Dist_RAM_sync: valid/ready request in, registered qspo read,
// read-modify-write for sub-word stores, held response out.
module dist_ram_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int RAM_AW = 6,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [RAM_AW-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    output logic              ram_qspo_ce,
    output logic              ram_qspo_srst,
    input  logic [DATA_W-1:0] ram_qspo
);
    import dist_ram_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

    state_t            state, state_nx;
    logic              srst_pend;
    size_t             req_sz;
    logic              req_err;
    logic              accept;
    size_t             size_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_data;

    assign req_sz = size_t'(req_size);

    always_comb begin
        case (req_sz)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = req_addr[0];
            SZ_W:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_L)
            req_err = 1'b1;
    end

    // srst_pend keeps the request side closed while the RAM output register is being cleared
    assign req_ready     = (state == ST_IDLE) && !srst_pend;
    assign accept        = req_valid && req_ready;
    assign rsp_valid     = (state == ST_RESP);
    assign ram_we        = (state == ST_WR);
    assign ram_qspo_ce   = (state == ST_RD);
    assign ram_qspo_srst = srst_pend;
    assign ram_d         = (state == ST_WR) ? st_data : d_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = ST_RESP;
                    else if (req_we && req_sz == SZ_W)
                        state_nx = ST_WR;
                    else
                        state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = we_q ? ST_WR : ST_LDAT;
            ST_LDAT: state_nx = ST_RESP;
            ST_WR:   state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            srst_pend <= 1'b1;
            size_q    <= SZ_B;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            addr_lo_q <= '0;
            wdata_q   <= '0;
            d_q       <= '0;
            ram_a     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            srst_pend <= 1'b0;
            if (accept) begin
                size_q    <= req_sz;
                we_q      <= req_we;
                uns_q     <= req_unsigned;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= req_err;
                if (!req_err)
                    ram_a <= req_addr[RAM_AW+1:2];
            end
            if (state == ST_LDAT)
                rsp_rdata <= ld_data;
            if (state == ST_WR)
                d_q <= st_data;
        end
    end

    dist_ram_lane_fmt u_lane_fmt (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .word        (ram_qspo),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_data     (st_data)
    );

endmodule

// File: tb/tb_dist_ram_port_ctrl.sv
// Bench for dist_ram_port_ctrl paired with a Dist_RAM_sync behavioural model.
module tb_dist_ram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  ram_a;
    logic [31:0] ram_d;
    logic        ram_we;
    logic        ram_qspo_ce;
    logic        ram_qspo_srst;
    logic [31:0] ram_qspo = '0;

    logic [31:0] ram_mem [64] = '{default: 32'h0};
    int          act_cnt = 0;
    int          we_cnt = 0;

    int total = 0;
    int bad = 0;

    logic [7:0] model_mem [128];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dist_ram_port_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .ram_a         (ram_a),
        .ram_d         (ram_d),
        .ram_we        (ram_we),
        .ram_qspo_ce   (ram_qspo_ce),
        .ram_qspo_srst (ram_qspo_srst),
        .ram_qspo      (ram_qspo)
    );

    // Dist_RAM_sync: synchronous write, registered read output with ce and sync reset
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_d;
        if (ram_qspo_srst) ram_qspo <= '0;
        else if (ram_qspo_ce) ram_qspo <= ram_mem[ram_a];
        if (ram_we || ram_qspo_ce) act_cnt <= act_cnt + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    function automatic logic model_err(input logic [7:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (int'(a) / 4 >= 32);
    endfunction

    function automatic int model_lat(input logic we, input logic [7:0] a, input logic [1:0] s);
        if (model_err(a, s)) return 1;
        if (we && s == 2'd2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] s, input logic uns);
        int          n = 1 << s;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    function automatic void model_store(input logic [7:0] a, input logic [1:0] s, input logic [31:0] wd);
        int n = 1 << s;
        for (int i = 0; i < n; i++) model_mem[int'(a) + i] = wd[8 * i +: 8];
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [7:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat, output logic ok);
        int guard = 0;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        rd = '0; e = 1'b0; lat = 0; ok = 1'b0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        ok = rsp_valid;
        rd = rsp_rdata;
        e  = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, held;
        logic        e, ok;
        int          lat, act0, we0;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wd;

        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst ram_qspo_ce", 32'(ram_qspo_ce), 32'd0);
        check("rst ram_a", 32'(ram_a), 32'd0);
        check("rst ram_d", ram_d, 32'd0);
        check("rst ram_qspo_srst", 32'(ram_qspo_srst), 32'd1);
        rst = 1'b0;
        #1;
        check("rel srst held", 32'(ram_qspo_srst), 32'd1);
        check("rel req_ready low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("post srst clear", 32'(ram_qspo_srst), 32'd0);
        check("post req_ready", 32'(req_ready), 32'd1);

        add(1, 2'd2, 0, 8'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        add(0, 2'd2, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 3);
        add(1, 2'd0, 0, 8'h12, 32'hFFFFFF5A, 32'h0, 0, 3);
        add(0, 2'd2, 0, 8'h10, 32'h0, 32'hDE5ABEEF, 0, 3);
        add(0, 2'd0, 0, 8'h13, 32'h0, 32'hFFFFFFDE, 0, 3);
        add(0, 2'd1, 1, 8'h12, 32'h0, 32'h0000DE5A, 0, 3);
        add(0, 2'd1, 0, 8'h11, 32'h0, 32'h0, 1, 1);
        add(0, 2'd2, 0, 8'h12, 32'h0, 32'h0, 1, 1);
        add(0, 2'd3, 0, 8'h00, 32'h0, 32'h0, 1, 1);
        add(0, 2'd2, 0, 8'h80, 32'h0, 32'h0, 1, 1);
        add(1, 2'd2, 0, 8'h80, 32'h12345678, 32'h0, 1, 1);
        add(1, 2'd1, 0, 8'h16, 32'hABCD1234, 32'h0, 0, 3);
        add(0, 2'd1, 0, 8'h16, 32'h0, 32'h00001234, 0, 3);
        add(0, 2'd0, 0, 8'h17, 32'h0, 32'h00000012, 0, 3);
        add(0, 2'd0, 1, 8'h15, 32'h0, 32'h00000000, 0, 3);
        add(1, 2'd2, 0, 8'h7C, 32'h80FF7F01, 32'h0, 0, 2);
        add(0, 2'd0, 0, 8'h7D, 32'h0, 32'h0000007F, 0, 3);
        add(0, 2'd0, 0, 8'h7E, 32'h0, 32'hFFFFFFFF, 0, 3);
        add(0, 2'd1, 0, 8'h7E, 32'h0, 32'hFFFF80FF, 0, 3);
        add(0, 2'd1, 1, 8'h7C, 32'h0, 32'h00007F01, 0, 3);
        add(0, 2'd0, 1, 8'h7F, 32'h0, 32'h00000080, 0, 3);

        foreach (vecs[i]) begin
            act0 = act_cnt;
            issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, e, lat, ok);
            check($sformatf("vec%0d handshake", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_err)
                check($sformatf("vec%0d ram idle on err", i), 32'(act_cnt - act0), 32'd0);
            if (vecs[i].we && !vecs[i].exp_err)
                model_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
        end
        check("ram mem[4]", ram_mem[4], 32'hDE5ABEEF);
        check("ram mem[5]", ram_mem[5], 32'h12340000);

        // held response with rsp_ready low; a competing request must be ignored
        rsp_ready = 1'b0;
        we0 = we_cnt;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("hold first rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_rdata;
        check("hold rdata", held, 32'hDE5ABEEF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold c%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("hold c%0d rdata", c), rsp_rdata, held);
            check($sformatf("hold c%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold released", 32'(rsp_valid), 32'd0);
        check("hold no write", 32'(we_cnt - we0), 32'd0);
        issue(0, 2'd2, 0, 8'h10, 32'h0, rd, e, lat, ok);
        check("hold mem intact", rd, 32'hDE5ABEEF);

        // reset during WR of a word store to word 0
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 8'h00;
        req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wr state ram_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-rst ram_we", 32'(ram_we), 32'd0);
        check("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-rst ram_a", 32'(ram_a), 32'd0);
        check("mid-rst ram_d", ram_d, 32'd0);
        check("mid-rst srst", 32'(ram_qspo_srst), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid-rst rel srst", 32'(ram_qspo_srst), 32'd1);
        check("mid-rst rel req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("mid-rst after srst", 32'(ram_qspo_srst), 32'd0);
        check("mid-rst after req_ready", 32'(req_ready), 32'd1);
        check("mid-rst mem[0]", ram_mem[0], 32'd0);
        issue(0, 2'd2, 0, 8'h00, 32'h0, rd, e, lat, ok);
        check("mid-rst load 0", rd, 32'd0);

        for (int n = 0; n < 1000; n++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 127));
            wd   = $urandom;
            issue(we, sz, uns, addr, wd, rd, e, lat, ok);
            check($sformatf("rnd%0d handshake", n), 32'(ok), 32'd1);
            check($sformatf("rnd%0d err", n), 32'(e), 32'(model_err(addr, sz)));
            check($sformatf("rnd%0d latency", n), 32'(lat), 32'(model_lat(we, addr, sz)));
            if (model_err(addr, sz) || we) begin
                check($sformatf("rnd%0d rdata", n), rd, 32'd0);
                if (!model_err(addr, sz)) model_store(addr, sz, wd);
            end else begin
                check($sformatf("rnd%0d rdata", n), rd, model_load(addr, sz, uns));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
